serial_cmd_decoder: RTL and testbench

SERIAL_CMD_DECODER -- requirements
Module: serial_cmd_decoder

---
 rtl/serial_cmd_decoder.sv | 179 +++++++++++++++++
 tb/tb_serial_cmd_decoder.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_cmd_decoder.sv
// Byte-serial command decoder: header/length/data packets driving a register bank.
// Optional idle timeout on partial packets when SERIAL_CMD_TIMEOUT_EN is defined.
module serial_cmd_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       cmdfifo_rxf,
    input  logic [7:0] cmdfifo_din,
    output logic       cmdfifo_rd,
    input  logic       cmdfifo_txe,
    output logic       cmdfifo_wr,
    output logic [7:0] cmdfifo_dout,
    output logic [5:0] reg_addr,
    output logic [7:0] reg_bytecnt,
    output logic [7:0] reg_datao,
    input  logic [7:0] reg_datai,
    output logic       reg_read,
    output logic       reg_write,
    output logic       reg_addrvalid,
    output logic       timeout_o
);

    typedef enum logic [2:0] {
        IDLE, LEN, WDATA, RREQ, RCAPT, RSEND
    } state_t;

    state_t     state_q, state_d;
    logic       rd_q, rd_d;
    logic       wr_q, wr_d;
    logic [7:0] dout_q, dout_d;
    logic [5:0] addr_q, addr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] datao_q, datao_d;
    logic       write_q, write_d;
    logic       av_q, av_d;
    logic       rnw_q, rnw_d;
    logic [8:0] rem_q, rem_d;
    logic       tmo_q, tmo_d;
    logic       accept;
    logic       expire;

    assign accept = cmdfifo_rxf && !rd_q &&
                    ((state_q == IDLE) || (state_q == LEN) || (state_q == WDATA));

`ifdef SERIAL_CMD_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          waiting;

    assign waiting = (state_q == LEN) || (state_q == WDATA);
    assign expire  = waiting && !accept && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tcnt_d = '0;
        if (waiting && !accept && !expire) tcnt_d = tcnt_q + TW'(1);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) tcnt_q <= '0;
        else            tcnt_q <= tcnt_d;
    end
`else
    // Keeps the parameter referenced when no counter is built.
    assign expire = (TIMEOUT_CYCLES == 0) & 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        rd_d    = accept;
        wr_d    = 1'b0;
        write_d = 1'b0;
        dout_d  = dout_q;
        addr_d  = addr_q;
        datao_d = datao_q;
        av_d    = av_q;
        rnw_d   = rnw_q;
        rem_d   = rem_q;
        tmo_d   = expire;
        // Write index advances after its strobe so reg_bytecnt matches reg_write.
        cnt_d   = write_q ? cnt_q + 8'd1 : cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = cmdfifo_din[5:0];
                    rnw_d   = cmdfifo_din[7];
                    state_d = LEN;
                end
            end
            LEN: begin
                if (accept) begin
                    rem_d   = (cmdfifo_din == 8'd0) ? 9'd256 : {1'b0, cmdfifo_din};
                    cnt_d   = 8'd0;
                    av_d    = 1'b1;
                    state_d = rnw_q ? RREQ : WDATA;
                end else if (expire) begin
                    av_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            WDATA: begin
                if (accept) begin
                    datao_d = cmdfifo_din;
                    write_d = 1'b1;
                    rem_d   = rem_q - 9'd1;
                    if (rem_q == 9'd1) begin
                        av_d    = 1'b0;
                        state_d = IDLE;
                    end
                end else if (expire) begin
                    av_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            RREQ: state_d = RCAPT;
            RCAPT: begin
                dout_d  = reg_datai;
                state_d = RSEND;
            end
            RSEND: begin
                if (cmdfifo_txe && !wr_q) begin
                    wr_d  = 1'b1;
                    cnt_d = cnt_q + 8'd1;
                    rem_d = rem_q - 9'd1;
                    if (rem_q == 9'd1) begin
                        av_d    = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = RREQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            dout_q  <= 8'd0;
            addr_q  <= 6'd0;
            cnt_q   <= 8'd0;
            datao_q <= 8'd0;
            write_q <= 1'b0;
            av_q    <= 1'b0;
            rnw_q   <= 1'b0;
            rem_q   <= 9'd0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            dout_q  <= dout_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            datao_q <= datao_d;
            write_q <= write_d;
            av_q    <= av_d;
            rnw_q   <= rnw_d;
            rem_q   <= rem_d;
            tmo_q   <= tmo_d;
        end
    end

    assign cmdfifo_rd    = rd_q;
    assign cmdfifo_wr    = wr_q;
    assign cmdfifo_dout  = dout_q;
    assign reg_addr      = addr_q;
    assign reg_bytecnt   = cnt_q;
    assign reg_datao     = datao_q;
    assign reg_read      = (state_q == RREQ);
    assign reg_write     = write_q;
    assign reg_addrvalid = av_q;
    assign timeout_o     = tmo_q;

endmodule

// File: tb/tb_serial_cmd_decoder.sv
// Randomized bench for serial_cmd_decoder with a packet-level reference model.
// Timeout scenario follows whichever build SERIAL_CMD_TIMEOUT_EN selects.
module tb_serial_cmd_decoder;

    logic       clk_i = 1'b0;
    logic       reset_n_i = 1'b0;
    logic       cmdfifo_rxf = 1'b0;
    logic [7:0] cmdfifo_din = 8'd0;
    logic       cmdfifo_rd;
    logic       cmdfifo_txe = 1'b0;
    logic       cmdfifo_wr;
    logic [7:0] cmdfifo_dout;
    logic [5:0] reg_addr;
    logic [7:0] reg_bytecnt;
    logic [7:0] reg_datao;
    logic [7:0] reg_datai = 8'd0;
    logic       reg_read;
    logic       reg_write;
    logic       reg_addrvalid;
    logic       timeout_o;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [5:0] a;
        logic [7:0] c;
        logic [7:0] d;
        logic       v;
    } wev_t;

    typedef struct packed {
        logic [7:0] d;
        logic       v;
    } tev_t;

    logic [7:0] rxq[$];
    wev_t       wq[$];
    tev_t       txq[$];
    logic [7:0] mem[256];
    int         nreads = 0;
    int         ntmo = 0;
    int         cyc = 0;
    int         rd_cyc = 0;
    int         tmo_cyc = 0;
    logic       rd_prev = 1'b0;
    logic       txe_s = 1'b0;
    wev_t       mev;
    tev_t       tev;

    always #5 clk_i = ~clk_i;

    serial_cmd_decoder #(.TIMEOUT_CYCLES(100)) dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .cmdfifo_rxf   (cmdfifo_rxf),
        .cmdfifo_din   (cmdfifo_din),
        .cmdfifo_rd    (cmdfifo_rd),
        .cmdfifo_txe   (cmdfifo_txe),
        .cmdfifo_wr    (cmdfifo_wr),
        .cmdfifo_dout  (cmdfifo_dout),
        .reg_addr      (reg_addr),
        .reg_bytecnt   (reg_bytecnt),
        .reg_datao     (reg_datao),
        .reg_datai     (reg_datai),
        .reg_read      (reg_read),
        .reg_write     (reg_write),
        .reg_addrvalid (reg_addrvalid),
        .timeout_o     (timeout_o)
    );

    // Register bank: data valid the cycle after the read strobe, noise otherwise.
    always @(posedge clk_i) begin
        txe_s <= cmdfifo_txe;
        if (reg_read) reg_datai <= mem[reg_bytecnt];
        else          reg_datai <= 8'($urandom);
    end

    // RX FIFO model plus event monitor, all on the falling edge.
    always @(negedge clk_i) begin
        cyc = cyc + 1;
        if (cmdfifo_rd && rxq.size() > 0) rxq.delete(0);
        cmdfifo_rxf = (rxq.size() != 0);
        cmdfifo_din = (rxq.size() != 0) ? rxq[0] : 8'h00;
        if (cmdfifo_rd) begin
            checks = checks + 1;
            if (rd_prev) begin
                errors = errors + 1;
                $display("FAIL rd_back_to_back: rd high on consecutive cycles at cycle %0d, required single-cycle pulse", cyc);
            end
            rd_cyc = cyc;
        end
        rd_prev = cmdfifo_rd;
        if (reg_write) begin
            mev.a = reg_addr;
            mev.c = reg_bytecnt;
            mev.d = reg_datao;
            mev.v = reg_addrvalid;
            wq.push_back(mev);
        end
        if (cmdfifo_wr) begin
            tev.d = cmdfifo_dout;
            tev.v = reg_addrvalid;
            txq.push_back(tev);
            checks = checks + 1;
            if (txe_s !== 1'b1) begin
                errors = errors + 1;
                $display("FAIL wr_without_txe: wr issued with txe=%b, required 1", txe_s);
            end
        end
        if (reg_read) nreads = nreads + 1;
        if (timeout_o) begin
            ntmo = ntmo + 1;
            tmo_cyc = cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset_n_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checks = checks + 1;
        if ({cmdfifo_rd, cmdfifo_wr, cmdfifo_dout, reg_addr, reg_bytecnt, reg_datao,
             reg_read, reg_write, reg_addrvalid, timeout_o} !== 36'd0) begin
            errors = errors + 1;
            $display("FAIL reset_outputs: got rd=%b wr=%b dout=%h addr=%h cnt=%h datao=%h rdst=%b wrst=%b av=%b tmo=%b, required all 0",
                     cmdfifo_rd, cmdfifo_wr, cmdfifo_dout, reg_addr, reg_bytecnt, reg_datao,
                     reg_read, reg_write, reg_addrvalid, timeout_o);
        end
        reset_n_i = 1'b1;
        repeat (2) @(negedge clk_i);
    endtask

    // Pushes a write packet, waits for its strobes and compares against the model.
    task automatic run_write(input string name, input logic [5:0] addr, input int n,
                             input logic [7:0] data[$]);
        int budget;
        logic [7:0] hdr;
        hdr = {1'b0, 1'($urandom), addr};
        wq.delete();
        rxq.push_back(hdr);
        rxq.push_back(8'(n));
        for (int i = 0; i < n; i++) rxq.push_back(data[i]);
        budget = 2 * n + 40;
        for (int i = 0; i < budget && wq.size() < n; i++) @(negedge clk_i);
        checks = checks + 1;
        if (wq.size() != n) begin
            errors = errors + 1;
            $display("FAIL %s_count: got %0d writes, required %0d", name, wq.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                checks = checks + 1;
                if (wq[i] !== {addr, 8'(i), data[i], 1'(i != n - 1)}) begin
                    errors = errors + 1;
                    $display("FAIL %s_write%0d: got addr=%h cnt=%h data=%h av=%b, required addr=%h cnt=%h data=%h av=%b",
                             name, i, wq[i].a, wq[i].c, wq[i].d, wq[i].v,
                             addr, 8'(i), data[i], (i != n - 1));
                end
            end
        end
        @(negedge clk_i);
        checks = checks + 1;
        if (reg_addrvalid !== 1'b0 || rxq.size() != 0) begin
            errors = errors + 1;
            $display("FAIL %s_idle: got addrvalid=%b rx_left=%0d, required 0 and 0",
                     name, reg_addrvalid, rxq.size());
        end
    endtask

    // Pushes a read packet and paces txe; wr bytes must equal bank contents.
    task automatic run_read(input string name, input logic [5:0] addr, input int n,
                            input int hold);
        int r0;
        logic [7:0] exp[$];
        for (int i = 0; i < n; i++) exp.push_back(mem[i]);
        txq.delete();
        r0 = nreads;
        rxq.push_back({1'b1, 1'($urandom), addr});
        rxq.push_back(8'(n));
        for (int k = 0; k < n; k++) begin
            cmdfifo_txe = 1'b0;
            repeat (hold) @(negedge clk_i);
            cmdfifo_txe = 1'b1;
            for (int i = 0; i < 40 && txq.size() <= k; i++) @(negedge clk_i);
            cmdfifo_txe = 1'b0;
        end
        repeat (2) @(negedge clk_i);
        checks = checks + 1;
        if (txq.size() != n || nreads - r0 != n) begin
            errors = errors + 1;
            $display("FAIL %s_count: got %0d wr and %0d reads, required %0d each",
                     name, txq.size(), nreads - r0, n);
        end else begin
            for (int i = 0; i < n; i++) begin
                checks = checks + 1;
                if (txq[i] !== {exp[i], 1'(i != n - 1)}) begin
                    errors = errors + 1;
                    $display("FAIL %s_byte%0d: got %h av=%b, required %h av=%b",
                             name, i, txq[i].d, txq[i].v, exp[i], (i != n - 1));
                end
            end
        end
        checks = checks + 1;
        if (reg_addr !== addr || reg_addrvalid !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL %s_end: got addr=%h av=%b, required addr=%h av=0",
                     name, reg_addr, reg_addrvalid, addr);
        end
    endtask

    task automatic test_write_basic();
        logic [7:0] d[$];
        d = '{8'hAA, 8'h55};
        run_write("write_basic", 6'd5, 2, d);
    endtask

    task automatic test_random_writes();
        logic [7:0] d[$];
        int n;
        for (int p = 0; p < 4; p++) begin
            d.delete();
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) d.push_back(8'($urandom));
            run_write("write_rand", 6'($urandom), n, d);
        end
    endtask

    task automatic test_length_zero();
        logic [7:0] d[$];
        for (int i = 0; i < 256; i++) d.push_back(8'($urandom));
        run_write("len0", 6'd1, 256, d);
        checks = checks + 1;
        if (reg_bytecnt !== 8'd0) begin
            errors = errors + 1;
            $display("FAIL len0_wrap: got bytecnt=%h, required 00", reg_bytecnt);
        end
    endtask

    task automatic test_read_backpressure();
        for (int i = 0; i < 256; i++) mem[i] = 8'(8'h10 + i);
        run_read("read_bp", 6'd3, 3, 20);
    endtask

    task automatic test_random_reads();
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            run_read("read_rand", 6'($urandom), $urandom_range(1, 5), $urandom_range(0, 4));
        end
    endtask

    // Write packet queued behind a read: must wait until the read finishes.
    task automatic test_back_to_back();
        logic [5:0] ra, wa;
        logic [7:0] d[3];
        ra = 6'($urandom);
        wa = 6'($urandom);
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 3; i++) d[i] = 8'($urandom);
        wq.delete();
        txq.delete();
        rxq.push_back({2'b10, ra});
        rxq.push_back(8'd2);
        rxq.push_back({2'b01, wa});
        rxq.push_back(8'd3);
        for (int i = 0; i < 3; i++) rxq.push_back(d[i]);
        cmdfifo_txe = 1'b1;
        for (int i = 0; i < 200 && (wq.size() < 3 || txq.size() < 2); i++) @(negedge clk_i);
        cmdfifo_txe = 1'b0;
        checks = checks + 1;
        if (txq.size() != 2 || wq.size() != 3) begin
            errors = errors + 1;
            $display("FAIL b2b_count: got %0d wr and %0d writes, required 2 and 3",
                     txq.size(), wq.size());
        end else begin
            checks = checks + 1;
            if (txq[0].d !== mem[0] || txq[1].d !== mem[1]) begin
                errors = errors + 1;
                $display("FAIL b2b_read: got %h %h, required %h %h",
                         txq[0].d, txq[1].d, mem[0], mem[1]);
            end
            for (int i = 0; i < 3; i++) begin
                checks = checks + 1;
                if (wq[i].a !== wa || wq[i].c !== 8'(i) || wq[i].d !== d[i]) begin
                    errors = errors + 1;
                    $display("FAIL b2b_write%0d: got addr=%h cnt=%h data=%h, required addr=%h cnt=%h data=%h",
                             i, wq[i].a, wq[i].c, wq[i].d, wa, 8'(i), d[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        wq.delete();
        rxq.push_back(8'h03);
        rxq.push_back(8'h04);
        rxq.push_back(8'hC3);
        for (int i = 0; i < 40 && wq.size() < 1; i++) @(negedge clk_i);
        @(negedge clk_i);
        @(posedge clk_i);
        #3;
        reset_n_i = 1'b0;
        #1;
        checks = checks + 1;
        if ({cmdfifo_rd, cmdfifo_wr, cmdfifo_dout, reg_addr, reg_bytecnt, reg_datao,
             reg_read, reg_write, reg_addrvalid, timeout_o} !== 36'd0) begin
            errors = errors + 1;
            $display("FAIL midreset_outputs: got addr=%h cnt=%h datao=%h av=%b, required all 0",
                     reg_addr, reg_bytecnt, reg_datao, reg_addrvalid);
        end
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
        @(negedge clk_i);
        wq.delete();
        rxq.push_back(8'h02);
        rxq.push_back(8'h01);
        rxq.push_back(8'h77);
        for (int i = 0; i < 40 && wq.size() < 1; i++) @(negedge clk_i);
        @(negedge clk_i);
        checks = checks + 1;
        if (wq.size() != 1 || wq[0].a !== 6'd2 || wq[0].d !== 8'h77 || wq[0].c !== 8'd0) begin
            errors = errors + 1;
            $display("FAIL midreset_fresh: got %0d writes first addr=%h data=%h, required 1 write addr=02 data=77",
                     wq.size(), (wq.size() > 0) ? wq[0].a : 6'h3f, (wq.size() > 0) ? wq[0].d : 8'hff);
        end
    endtask

    task automatic test_timeout();
        int t0;
        logic [7:0] d[$];
        t0 = ntmo;
        rxq.push_back(8'h04);
`ifdef SERIAL_CMD_TIMEOUT_EN
        for (int i = 0; i < 300 && ntmo == t0; i++) @(negedge clk_i);
        repeat (20) @(negedge clk_i);
        checks = checks + 1;
        if (ntmo - t0 != 1 || tmo_cyc - rd_cyc != 100) begin
            errors = errors + 1;
            $display("FAIL timeout_pulse: got %0d pulses at +%0d cycles, required 1 at +100",
                     ntmo - t0, tmo_cyc - rd_cyc);
        end
        d = '{8'h5A};
        run_write("after_timeout", 6'd2, 1, d);
`else
        repeat (200) @(negedge clk_i);
        checks = checks + 1;
        if (ntmo != t0 || timeout_o !== 1'b0 || rxq.size() != 0) begin
            errors = errors + 1;
            $display("FAIL no_timeout: got %0d pulses rx_left=%0d, required 0 and 0",
                     ntmo - t0, rxq.size());
        end
        wq.delete();
        rxq.push_back(8'h01);
        rxq.push_back(8'h3C);
        for (int i = 0; i < 40 && wq.size() < 1; i++) @(negedge clk_i);
        @(negedge clk_i);
        checks = checks + 1;
        if (wq.size() != 1 || wq[0].a !== 6'd4 || wq[0].d !== 8'h3C) begin
            errors = errors + 1;
            $display("FAIL stay_in_len: got %0d writes, required 1 write of 3C to addr 04",
                     wq.size());
        end
`endif
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_backpressure();
        test_length_zero();
        test_random_writes();
        test_random_reads();
        test_back_to_back();
        test_reset_mid_packet();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
